des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule generator. It loads a 64-bit cipher key and produces the 48-bit round subkeys K1..K16 one per advance request: ascending order for encryption, descending (K16..K1) for decryption. It sits upstream of the round datapath and replaces the constant per-round subkey sources feeding the 16-way subkey selector. It also emits the 5-bit subkey index in the same encoding that selector uses (0 = K1 … 15 = K16).

## Interface
Parameters: none.

Clock and reset (already decided): one clock, `clk`. Reset `rst_n` is synchronous and active-low.

Ports:
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `key` in [64:1] — cipher key. DES bit i (FIPS numbering, 1 = leftmost) maps to `key[65-i]`. Parity bits 8,16,…,64 are ignored.
- `key_load` in 1 — capture `key` and start a schedule.
- `decrypt` in 1 — sampled only with `key_load`. 0 = K1→K16, 1 = K16→K1.
- `next` in 1 — advance to the following subkey.
- `K` out [48:1] — current subkey, registered. DES bit j maps to `K[49-j]`.
- `key_idx` out [1:5] — index of the subkey on `K`, 0..15 (Kn ⇒ n-1).
- `rnd` out [1:5] — step count since load, 0..15.
- `k_valid` out 1 — `K`, `key_idx` and `rnd` are meaningful.
- `done` out 1 — one-cycle pulse after the final subkey has been consumed.

## Operation
- Internal registers:
  - `C`, `D` (28 b each).
  - `dir` (latched `decrypt`).
  - state IDLE / ACTIVE.
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- PC-1 and PC-2 are the FIPS 46-3 tables, hard-wired.

Load (any state, `key_load`=1):
- Compute {C0,D0} = PC-1(key).
- Encrypt: {C,D} ← {C0,D0} each rotated left by s[1]. `K` ← PC-2 of that, which is K1. `key_idx` ← 0.
- Decrypt: {C,D} ← {C0,D0} unrotated, since C16 = C0 because total rotation is 28. `K` ← K16. `key_idx` ← 15.
- `rnd` ← 0, `k_valid` ← 1, `dir` ← `decrypt`, state ← ACTIVE.

Advance (ACTIVE, `next`=1, `key_load`=0, `rnd` < 15):
- Encrypt, currently Kn: C, D rotate left by s[n+1]. `K` ← K(n+1). `key_idx`++.
- Decrypt, currently Kn: C, D rotate right by s[n]. `K` ← K(n-1). `key_idx`--.
- `rnd`++.

Final advance (ACTIVE, `next`=1, `rnd` = 15):
- state ← IDLE, `k_valid` ← 0, `done` ← 1 for one cycle.
- `K`, `key_idx`, `rnd` hold their last values.

Boundary and priority rules:
- `next` in IDLE is ignored. `done` stays 0.
- `key_load` and `next` in the same cycle: load wins and `next` is discarded. This applies mid-schedule too: the current schedule is aborted, the new key is loaded, and no `done` is generated.
- `key_load` in the cycle `done` would be asserted (`rnd`=15 with `next`): load wins and `done` is not pulsed.
- `decrypt` changing while ACTIVE has no effect until the next load.
- `key` changing while ACTIVE has no effect. The key is held only in C/D.
- Reset mid-schedule aborts it. All outputs take their reset values.

Reset values (`rst_n`=0 at a rising edge):
- `K` = 0, `key_idx` = 0, `rnd` = 0, `k_valid` = 0, `done` = 0.
- C = D = 0, `dir` = 0, state = IDLE.

## Timing
- Every output is a register. No combinational path runs from inputs to outputs.
- Load latency: `key_load` sampled at edge t ⇒ first subkey and `k_valid`=1 are visible after edge t.
- Advance latency: `next` sampled at edge t ⇒ the new subkey is visible after edge t. `next` may be held high continuously, giving one subkey per cycle.
- A full schedule is 1 load plus 16 `next` cycles. The 16th `next` produces `done` after its edge; `k_valid` falls on that same edge.
- Critical path: PC-1/rotate mux → PC-2 → `K` register. Pure wiring plus a 3:1 rotate mux per bit. No arithmetic beyond the 5-bit `rnd` and `key_idx` counters, and neither counter wraps.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs ⇒ all outputs 0 and IDLE. `next` pulses afterwards ⇒ no `k_valid`, no `done`.
- Encrypt vector: `key`=64'h133457799BBCDFF1, `decrypt`=0, load ⇒ `K`=48'h1B02EFFC7072, `key_idx`=0. After 1 `next` ⇒ 48'h79AED9DBC9E5, `key_idx`=1. After 15 `next` ⇒ 48'hCB3D8B0E17F5, `key_idx`=15. The 16th `next` ⇒ `done`=1 for exactly one cycle and `k_valid`=0.
- Decrypt vector: same key, `decrypt`=1 ⇒ first `K`=48'hCB3D8B0E17F5 with `key_idx`=15. Second ⇒ 48'hBF918D3D3F0A with `key_idx`=14. Sixteenth ⇒ 48'h1B02EFFC7072 with `key_idx`=0. The full sequence must equal the encrypt sequence reversed.
- Parity ignored: `key`=64'h0101010101010101 ⇒ all 16 subkeys are 0, and `done` arrives after 16 `next`.
- Priority: at `rnd`=7, assert `key_load` and `next` together with a new key ⇒ `rnd`=0 and `K` = K1 of the new key, with no `done`. Also assert `key_load` in the `rnd`=15 `next` cycle ⇒ no `done` pulse.
- Mid-run reset: assert `rst_n`=0 at `rnd`=9 ⇒ after that edge all outputs are 0, and a subsequent `next` has no effect.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Key-schedule bus: key load/advance requests in, current subkey and status out.
interface des_key_schedule_if;
  logic [64:1] key;
  logic        key_load;
  logic        decrypt;
  logic        next;
  logic [48:1] K;
  logic [4:0]  key_idx;
  logic [4:0]  rnd;
  logic        k_valid;
  logic        done;

  modport master (
    output key, key_load, decrypt, next,
    input  K, key_idx, rnd, k_valid, done
  );

  modport slave (
    input  key, key_load, decrypt, next,
    output K, key_idx, rnd, k_valid, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit round subkey per advance, K1..K16 or K16..K1.
// C/D hold the rotated key halves; PC-2 of the next C/D is registered straight into K.
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_schedule_if.slave    bus
);

  localparam int unsigned CD_W  = 56;
  localparam int unsigned K_W   = 48;
  localparam int unsigned IDX_W = 5;

  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [K_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit n-1 set means round n rotates by two positions instead of one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              dir_q, dir_d;
  logic [K_W:1]      k_q, k_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              unused_parity;

  // DES bit b of C||D lives at cd[56-b]; DES key bit i lives at key[65-i].
  function automatic logic [CD_W-1:0] pc1(input logic [64:1] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[65-PC1[i]];
    return r;
  endfunction

  function automatic logic [K_W:1] pc2(input logic [CD_W-1:0] cd);
    logic [K_W:1] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[48-j] = cd[56-PC2[j]];
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    return two ? {c[25:0], c[27:26], d[25:0], d[27:26]}
               : {c[26:0], c[27],    d[26:0], d[27]};
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    return two ? {c[1:0], c[27:2], d[1:0], d[27:2]}
               : {c[0],   c[27:1], d[0],   d[27:1]};
  endfunction

  // Parity bits 8,16,...,64 play no part in the schedule.
  assign unused_parity = ^{bus.key[57], bus.key[49], bus.key[41], bus.key[33],
                           bus.key[25], bus.key[17], bus.key[9],  bus.key[1]};

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    dir_d   = dir_q;
    k_d     = k_q;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (bus.key_load) begin
      // Decrypt starts from C0/D0 unrotated: total rotation is 28, so C16 = C0.
      cd_d    = bus.decrypt ? pc1(bus.key) : rotl(pc1(bus.key), 1'b0);
      k_d     = pc2(cd_d);
      idx_d   = bus.decrypt ? IDX_W'(15) : IDX_W'(0);
      rnd_d   = '0;
      valid_d = 1'b1;
      dir_d   = bus.decrypt;
      state_d = ACTIVE;
    end else if (state_q == ACTIVE && bus.next) begin
      if (rnd_q == IDX_W'(15)) begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        if (dir_q) begin
          cd_d  = rotr(cd_q, SHIFT2[idx_q[3:0]]);
          idx_d = idx_q - IDX_W'(1);
        end else begin
          cd_d  = rotl(cd_q, SHIFT2[4'(idx_q + IDX_W'(1))]);
          idx_d = idx_q + IDX_W'(1);
        end
        k_d   = pc2(cd_d);
        rnd_d = rnd_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      dir_q   <= 1'b0;
      k_q     <= '0;
      idx_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      dir_q   <= dir_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.K       = k_q;
  assign bus.key_idx = idx_q;
  assign bus.rnd     = rnd_q;
  assign bus.k_valid = valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer subkey tables plus priority and reset cases.
module tb_des_key_schedule;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  des_key_schedule_if bus ();

  des_key_schedule u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P  = 64'h0101010101010101;
  localparam logic [63:0] KEY_F  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] ONES48 = 48'hFFFFFFFFFFFF;

  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          steps;
    logic [47:0] exp_k;
    logic [4:0]  exp_idx;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [63:0] k, input logic dec);
    bus.key      = k;
    bus.decrypt  = dec;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  task automatic step();
    bus.next = 1'b1;
    tick();
    bus.next = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".K"},       64'(bus.K),       64'd0);
    chk({name, ".key_idx"}, 64'(bus.key_idx), 64'd0);
    chk({name, ".rnd"},     64'(bus.rnd),     64'd0);
    chk({name, ".k_valid"}, 64'(bus.k_valid), 64'd0);
    chk({name, ".done"},    64'(bus.done),    64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{KEY_A, 1'b0,  0, ks[0],  5'd0};
    vecs[1] = '{KEY_A, 1'b0,  1, ks[1],  5'd1};
    vecs[2] = '{KEY_A, 1'b0, 15, ks[15], 5'd15};
    vecs[3] = '{KEY_A, 1'b1,  0, ks[15], 5'd15};
    vecs[4] = '{KEY_A, 1'b1,  1, ks[14], 5'd14};
    vecs[5] = '{KEY_A, 1'b1, 15, ks[0],  5'd0};
    vecs[6] = '{KEY_P, 1'b0,  5, 48'd0,  5'd5};
    vecs[7] = '{KEY_P, 1'b1, 15, 48'd0,  5'd0};
    vecs[8] = '{KEY_F, 1'b0,  8, ONES48, 5'd8};
    vecs[9] = '{KEY_F, 1'b1,  3, ONES48, 5'd12};

    // Reset with random inputs toggling underneath it.
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.key      = {$urandom, $urandom};
      bus.key_load = 1'($urandom_range(0, 1));
      bus.decrypt  = 1'($urandom_range(0, 1));
      bus.next     = 1'($urandom_range(0, 1));
      tick();
    end
    chk_zero("reset");
    rst_n        = 1'b1;
    bus.key_load = 1'b0;
    bus.next     = 1'b0;
    bus.decrypt  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_next.k_valid", 64'(bus.k_valid), 64'd0);
      chk("idle_next.done",    64'(bus.done),    64'd0);
    end

    // Full encrypt schedule while key/decrypt inputs wander.
    load(KEY_A, 1'b0);
    chk("enc.K0",   64'(bus.K),       64'(ks[0]));
    chk("enc.idx0", 64'(bus.key_idx), 64'd0);
    chk("enc.rnd0", 64'(bus.rnd),     64'd0);
    chk("enc.val0", 64'(bus.k_valid), 64'd1);
    for (int i = 1; i < 16; i++) begin
      bus.key     = {$urandom, $urandom};
      bus.decrypt = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("enc.K%0d", i),   64'(bus.K),       64'(ks[i]));
      chk($sformatf("enc.idx%0d", i), 64'(bus.key_idx), 64'(i));
      chk($sformatf("enc.rnd%0d", i), 64'(bus.rnd),     64'(i));
      chk($sformatf("enc.done%0d", i), 64'(bus.done),   64'd0);
    end
    step();
    chk("enc.done",      64'(bus.done),    64'd1);
    chk("enc.valid_end", 64'(bus.k_valid), 64'd0);
    chk("enc.K_hold",    64'(bus.K),       64'(ks[15]));
    chk("enc.idx_hold",  64'(bus.key_idx), 64'd15);
    chk("enc.rnd_hold",  64'(bus.rnd),     64'd15);
    tick();
    chk("enc.done_pulse", 64'(bus.done), 64'd0);

    // Full decrypt schedule must be the encrypt sequence reversed.
    load(KEY_A, 1'b1);
    chk("dec.K0",   64'(bus.K),       64'(ks[15]));
    chk("dec.idx0", 64'(bus.key_idx), 64'd15);
    for (int i = 1; i < 16; i++) begin
      bus.decrypt = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("dec.K%0d", i),   64'(bus.K),       64'(ks[15-i]));
      chk($sformatf("dec.idx%0d", i), 64'(bus.key_idx), 64'(15 - i));
      chk($sformatf("dec.rnd%0d", i), 64'(bus.rnd),     64'(i));
    end
    step();
    chk("dec.done",      64'(bus.done),    64'd1);
    chk("dec.valid_end", 64'(bus.k_valid), 64'd0);
    tick();
    chk("dec.done_pulse", 64'(bus.done), 64'd0);

    // Table of spot vectors, each run through to its done pulse.
    for (int v = 0; v < 10; v++) begin
      load(vecs[v].key, vecs[v].dec);
      for (int s = 0; s < vecs[v].steps; s++) step();
      chk($sformatf("vec%0d.K", v),   64'(bus.K),       64'(vecs[v].exp_k));
      chk($sformatf("vec%0d.idx", v), 64'(bus.key_idx), 64'(vecs[v].exp_idx));
      chk($sformatf("vec%0d.rnd", v), 64'(bus.rnd),     64'(vecs[v].steps));
      chk($sformatf("vec%0d.val", v), 64'(bus.k_valid), 64'd1);
      for (int s = vecs[v].steps; s < 15; s++) step();
      chk($sformatf("vec%0d.pre_done", v), 64'(bus.done), 64'd0);
      step();
      chk($sformatf("vec%0d.done", v),    64'(bus.done),    64'd1);
      chk($sformatf("vec%0d.val_end", v), 64'(bus.k_valid), 64'd0);
    end

    // Load and next together at rnd 7: new key wins, no done.
    load(KEY_A, 1'b0);
    for (int s = 0; s < 7; s++) step();
    chk("prio7.rnd_before", 64'(bus.rnd), 64'd7);
    bus.key      = KEY_F;
    bus.decrypt  = 1'b0;
    bus.key_load = 1'b1;
    bus.next     = 1'b1;
    tick();
    bus.key_load = 1'b0;
    bus.next     = 1'b0;
    chk("prio7.rnd",  64'(bus.rnd),     64'd0);
    chk("prio7.K",    64'(bus.K),       64'(ONES48));
    chk("prio7.idx",  64'(bus.key_idx), 64'd0);
    chk("prio7.val",  64'(bus.k_valid), 64'd1);
    chk("prio7.done", 64'(bus.done),    64'd0);

    // Load in the cycle that would have produced done.
    load(KEY_A, 1'b1);
    for (int s = 0; s < 15; s++) step();
    chk("prio15.K_before", 64'(bus.K), 64'(ks[0]));
    bus.key      = KEY_A;
    bus.decrypt  = 1'b0;
    bus.key_load = 1'b1;
    bus.next     = 1'b1;
    tick();
    bus.key_load = 1'b0;
    bus.next     = 1'b0;
    chk("prio15.done", 64'(bus.done),    64'd0);
    chk("prio15.val",  64'(bus.k_valid), 64'd1);
    chk("prio15.rnd",  64'(bus.rnd),     64'd0);
    chk("prio15.idx",  64'(bus.key_idx), 64'd0);
    chk("prio15.K",    64'(bus.K),       64'(ks[0]));
    tick();
    chk("prio15.done_after", 64'(bus.done), 64'd0);

    // Reset in the middle of a schedule.
    load(KEY_A, 1'b0);
    for (int s = 0; s < 9; s++) step();
    chk("midrst.rnd_before", 64'(bus.rnd), 64'd9);
    rst_n = 1'b0;
    tick();
    chk_zero("midrst");
    rst_n = 1'b1;
    step();
    chk_zero("midrst_next");
    tick();
    chk("midrst.done_late", 64'(bus.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
